// File: rtl/player_pkg.sv
// Shared types and defaults for the player motion controller: state encoding,
// physics defaults and the bit positions inside game_tick.
package player_pkg;

   typedef enum logic [2:0] {
      ST_RESTART   = 3'd0,
      ST_RUNNING   = 3'd1,
      ST_DUCKING   = 3'd2,
      ST_ASCEND    = 3'd3,
      ST_DESCEND   = 3'd4,
      ST_GAME_OVER = 3'd5
   } state_t;

   localparam int DEF_POS_W         = 8;
   localparam int DEF_VEL_W         = 6;
   localparam int DEF_JUMP_VEL      = 6;
   localparam int DEF_GRAVITY       = 1;
   localparam int DEF_HOLD_TICKS    = 3;
   localparam int DEF_FAST_FALL_MUL = 2;
   localparam int DEF_BUF_TICKS     = 4;

   localparam int TICK_INPUT = 0;
   localparam int TICK_PHYS  = 1;

   function automatic logic is_airborne(input state_t s);
      return (s == ST_ASCEND) || (s == ST_DESCEND);
   endfunction

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Bundle of game-side inputs and renderer-side outputs of the player motion controller.
// master drives ticks/buttons/crash, slave is the controller itself.
interface player_motion_ctrl_if #(
   parameter int POS_W = 8
);
   logic [1:0]       game_tick;
   logic             button_up;
   logic             button_down;
   logic             crash;
   logic [POS_W-1:0] player_position;
   logic             game_start_pulse;
   logic             game_over_pulse;
   logic             jump_pulse;
   logic             jumping;
   logic             ducking;

   modport master (
      output game_tick, button_up, button_down, crash,
      input  player_position, game_start_pulse, game_over_pulse, jump_pulse, jumping, ducking
   );

   modport slave (
      input  game_tick, button_up, button_down, crash,
      output player_position, game_start_pulse, game_over_pulse, jump_pulse, jumping, ducking
   );
endinterface

// File: rtl/player_kinematics.sv
// Jump physics: height/velocity registers, hold-to-extend, fast fall,
// velocity saturation, ceiling clamp and landing detection.
module player_kinematics
   import player_pkg::*;
#(
   parameter int POS_W         = DEF_POS_W,
   parameter int VEL_W         = DEF_VEL_W,
   parameter int JUMP_VEL      = DEF_JUMP_VEL,
   parameter int GRAVITY       = DEF_GRAVITY,
   parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
   parameter int FAST_FALL_MUL = DEF_FAST_FALL_MUL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             takeoff,
   input  logic             step,
   input  logic             ascending,
   input  logic             button_up,
   input  logic             button_down,
   output logic [POS_W-1:0] pos,
   output logic             landed,
   output logic             apex
);
   localparam int SW = POS_W + 2;
   localparam int VW = VEL_W + 2;
   localparam int HW = $clog2(HOLD_TICKS + 1);

   localparam logic signed [SW-1:0]    POS_MAX  = SW'((2 ** POS_W) - 1);
   localparam logic signed [VW-1:0]    VEL_MIN  = VW'(-(2 ** (VEL_W - 1)));
   localparam logic signed [VW-1:0]    DEC_NORM = VW'(GRAVITY);
   localparam logic signed [VW-1:0]    DEC_FAST = VW'(GRAVITY * FAST_FALL_MUL);
   localparam logic signed [VEL_W-1:0] VEL_JUMP = VEL_W'(JUMP_VEL);
   localparam logic [HW-1:0]           HOLD_MAX = HW'(HOLD_TICKS);

   logic [POS_W-1:0]        pos_reg;
   logic signed [VEL_W-1:0] vel_reg;
   logic [HW-1:0]           hold_reg;

   logic signed [SW-1:0]    pos_sum;
   logic signed [VW-1:0]    vel_dec, vel_calc;
   logic signed [VEL_W-1:0] vel_sat, vel_next;
   logic                    hold_ext, clamp, land;

   // Position moves with the old velocity; velocity is updated afterwards.
   always_comb begin
      pos_sum  = $signed({2'b00, pos_reg}) + SW'(vel_reg);
      hold_ext = ascending && button_up && (hold_reg < HOLD_MAX);
      vel_dec  = hold_ext ? '0 : (button_down ? DEC_FAST : DEC_NORM);
      vel_calc = VW'(vel_reg) - vel_dec;
      vel_sat  = (vel_calc < VEL_MIN) ? VEL_MIN[VEL_W-1:0] : vel_calc[VEL_W-1:0];
      clamp    = pos_sum > POS_MAX;
      land     = pos_sum[SW-1] || (pos_sum == '0);
      vel_next = (clamp || land) ? '0 : vel_sat;
      landed   = step && land;
      apex     = step && ascending && !land && (vel_next[VEL_W-1] || (vel_next == '0));
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         pos_reg  <= '0;
         vel_reg  <= '0;
         hold_reg <= '0;
      end else begin
         if (step) begin
            pos_reg <= clamp ? POS_MAX[POS_W-1:0] : (land ? '0 : pos_sum[POS_W-1:0]);
            vel_reg <= vel_next;
            if (hold_ext) hold_reg <= hold_reg + 1'b1;
         end
         // A buffered jump can take off on the landing clock, so takeoff wins over step.
         if (takeoff) begin
            vel_reg  <= VEL_JUMP;
            hold_reg <= '0;
         end
      end
   end

   assign pos = pos_reg;

endmodule

// File: rtl/player_motion_ctrl.sv
// Player game/motion FSM with integrated jump physics and event pulses.
// Optional build macro JUMP_BUFFER_EN: remembers a jump press made while airborne.
module player_motion_ctrl
   import player_pkg::*;
#(
   parameter int POS_W         = DEF_POS_W,
   parameter int VEL_W         = DEF_VEL_W,
   parameter int JUMP_VEL      = DEF_JUMP_VEL,
   parameter int GRAVITY       = DEF_GRAVITY,
   parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
   parameter int FAST_FALL_MUL = DEF_FAST_FALL_MUL,
   parameter int BUF_TICKS     = DEF_BUF_TICKS
) (
   input logic                 clk,
   input logic                 reset,
   player_motion_ctrl_if.slave bus
);
   state_t state_reg, state_next;

   logic tick_in, tick_ph, airborne, crash_evt, step;
   logic takeoff, start_evt, kin_clear, landed, apex, buf_hit;
   logic start_reg, start_next, over_reg, over_next, jump_reg, jump_next;
   logic jumping_reg, jumping_next, ducking_reg, ducking_next;
   logic [POS_W-1:0] pos;

   assign tick_in   = bus.game_tick[TICK_INPUT];
   assign tick_ph   = bus.game_tick[TICK_PHYS];
   assign airborne  = is_airborne(state_reg);
   assign crash_evt = tick_in && bus.crash &&
                      (state_reg inside {ST_RUNNING, ST_DUCKING, ST_ASCEND, ST_DESCEND});
   // A crash on the same clock freezes the height where it is.
   assign step      = tick_ph && airborne && !crash_evt;

   player_kinematics #(
      .POS_W(POS_W), .VEL_W(VEL_W), .JUMP_VEL(JUMP_VEL), .GRAVITY(GRAVITY),
      .HOLD_TICKS(HOLD_TICKS), .FAST_FALL_MUL(FAST_FALL_MUL)
   ) u_kin (
      .clk(clk), .reset(reset), .clear(kin_clear), .takeoff(takeoff), .step(step),
      .ascending(state_reg == ST_ASCEND), .button_up(bus.button_up),
      .button_down(bus.button_down), .pos(pos), .landed(landed), .apex(apex)
   );

`ifdef JUMP_BUFFER_EN
   localparam int BW = $clog2(BUF_TICKS + 1);
   logic [BW-1:0] buf_cnt_reg;
   logic          up_smp_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_cnt_reg <= '0;
         up_smp_reg  <= 1'b0;
      end else begin
         if (tick_in) up_smp_reg <= bus.button_up;
         if (takeoff || crash_evt)
            buf_cnt_reg <= '0;
         else if (tick_in && airborne && bus.button_up && !up_smp_reg)
            buf_cnt_reg <= BW'(BUF_TICKS);
         else if (tick_in && (buf_cnt_reg != '0))
            buf_cnt_reg <= buf_cnt_reg - 1'b1;
      end
   end

   assign buf_hit = (buf_cnt_reg != '0);
`else
   // Buffering compiled out: never true.
   assign buf_hit = (BUF_TICKS < 0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_RESTART;
         start_reg   <= 1'b0;
         over_reg    <= 1'b0;
         jump_reg    <= 1'b0;
         jumping_reg <= 1'b0;
         ducking_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         start_reg   <= start_next;
         over_reg    <= over_next;
         jump_reg    <= jump_next;
         jumping_reg <= jumping_next;
         ducking_reg <= ducking_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      takeoff    = 1'b0;
      start_evt  = 1'b0;
      kin_clear  = 1'b0;
      case (state_reg)
         ST_RESTART: if (tick_in && bus.button_up) begin
            state_next = ST_RUNNING;
            start_evt  = 1'b1;
         end
         ST_RUNNING: begin
            if (crash_evt) state_next = ST_GAME_OVER;
            else if (tick_in && bus.button_down) state_next = ST_DUCKING;
            else if (tick_in && bus.button_up) begin
               state_next = ST_ASCEND;
               takeoff    = 1'b1;
            end
         end
         ST_DUCKING: begin
            if (crash_evt) state_next = ST_GAME_OVER;
            else if (tick_in && !bus.button_down) state_next = ST_RUNNING;
         end
         ST_ASCEND, ST_DESCEND: begin
            if (crash_evt) state_next = ST_GAME_OVER;
            else if (landed) begin
               state_next = buf_hit ? ST_ASCEND : ST_RUNNING;
               takeoff    = buf_hit;
            end else if (apex) state_next = ST_DESCEND;
         end
         ST_GAME_OVER: if (tick_in && bus.button_up) begin
            state_next = ST_RUNNING;
            start_evt  = 1'b1;
            kin_clear  = 1'b1;
         end
         default: state_next = ST_RESTART;
      endcase
   end

   always_comb begin
      start_next   = start_evt;
      jump_next    = takeoff;
      over_next    = (state_next == ST_GAME_OVER) && (state_reg != ST_GAME_OVER);
      jumping_next = is_airborne(state_next);
      ducking_next = (state_next == ST_DUCKING);
   end

   assign bus.player_position  = pos;
   assign bus.game_start_pulse = start_reg;
   assign bus.game_over_pulse  = over_reg;
   assign bus.jump_pulse       = jump_reg;
   assign bus.jumping          = jumping_reg;
   assign bus.ducking          = ducking_reg;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: FSM vector table, then jump sequences whose
// expected heights are queued at takeoff and popped on every physics tick.
module tb_player_motion_ctrl;

   typedef struct {
      logic [1:0]  tick;
      logic        up;
      logic        dn;
      logic        cr;
      logic [12:0] exp;   // {pos, start, over, jump, jumping, ducking}
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int n_tests  = 0;
   int n_fail   = 0;
   int phys_cnt = 0;
   int t1_ticks = 0;
   int pulses   = 0;
   int exp_q[$];
   vec_t vecs[16];

   int h_plain[13] = '{6, 11, 15, 18, 20, 21, 21, 20, 18, 15, 11, 6, 0};
   int h_hold[19]  = '{6, 12, 18, 24, 29, 33, 36, 38, 39, 39, 38, 36, 33, 29, 24, 18, 11, 3, 0};
   int h_fast[12]  = '{6, 11, 15, 18, 20, 21, 21, 20, 17, 12, 5, 0};

   player_motion_ctrl_if #(.POS_W(8)) bus ();

   player_motion_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   function automatic logic [12:0] outs();
      return {bus.player_position, bus.game_start_pulse, bus.game_over_pulse,
              bus.jump_pulse, bus.jumping, bus.ducking};
   endfunction

   function automatic logic [1:0] phase_tick(input int k);
      case (k % 4)
         1:       return 2'b01;
         3:       return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic [1:0] tick, input logic up, input logic dn, input logic cr);
      int e;
      bus.game_tick   = tick;
      bus.button_up   = up;
      bus.button_down = dn;
      bus.crash       = cr;
      @(posedge clk);
      #1;
      pulses += int'(bus.game_start_pulse) + int'(bus.game_over_pulse) + int'(bus.jump_pulse);
      if (tick[1] && (exp_q.size() > 0)) begin
         e = exp_q.pop_front();
         phys_cnt++;
         $display("[TB] phys tick %0d: pos %0d (expected %0d) jumping %0d",
                  phys_cnt, bus.player_position, e, bus.jumping);
         check("height", 32'(bus.player_position), 32'(e));
         check("airborne", 32'(bus.jumping), (e != 0) ? 32'd1 : 32'd0);
         check("no_duck_in_air", 32'(bus.ducking), 32'd0);
      end
   endtask

   task automatic fly(input logic up_lvl, input int down_from, input int max_clk);
      for (int k = 0; (k < max_clk) && (exp_q.size() > 0); k++)
         step(phase_tick(k), up_lvl, logic'(phys_cnt >= down_from), 1'b0);
      if (exp_q.size() > 0) begin
         check("fly_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic do_takeoff(input string name);
      phys_cnt = 0;
      step(2'b01, 1'b1, 1'b0, 1'b0);
      $display("[TB] %s: takeoff jump_pulse %0d jumping %0d", name, bus.jump_pulse, bus.jumping);
      check({name, "_jump_pulse"}, 32'(bus.jump_pulse), 32'd1);
      check({name, "_jumping"}, 32'(bus.jumping), 32'd1);
   endtask

   initial begin
      vecs[0]  = '{2'b00, 1'b1, 1'b0, 1'b0, {8'd0, 5'b00000}};
      vecs[1]  = '{2'b01, 1'b0, 1'b0, 1'b0, {8'd0, 5'b00000}};
      vecs[2]  = '{2'b01, 1'b1, 1'b0, 1'b0, {8'd0, 5'b10000}};
      vecs[3]  = '{2'b00, 1'b0, 1'b0, 1'b0, {8'd0, 5'b00000}};
      vecs[4]  = '{2'b01, 1'b0, 1'b1, 1'b0, {8'd0, 5'b00001}};
      vecs[5]  = '{2'b01, 1'b1, 1'b1, 1'b0, {8'd0, 5'b00001}};
      vecs[6]  = '{2'b01, 1'b0, 1'b0, 1'b0, {8'd0, 5'b00000}};
      vecs[7]  = '{2'b01, 1'b0, 1'b0, 1'b1, {8'd0, 5'b01000}};
      vecs[8]  = '{2'b00, 1'b0, 1'b0, 1'b1, {8'd0, 5'b00000}};
      vecs[9]  = '{2'b01, 1'b0, 1'b0, 1'b1, {8'd0, 5'b00000}};
      vecs[10] = '{2'b01, 1'b1, 1'b0, 1'b0, {8'd0, 5'b10000}};
      vecs[11] = '{2'b01, 1'b1, 1'b0, 1'b0, {8'd0, 5'b00110}};
      vecs[12] = '{2'b00, 1'b0, 1'b0, 1'b0, {8'd0, 5'b00010}};
      vecs[13] = '{2'b01, 1'b0, 1'b0, 1'b1, {8'd0, 5'b01000}};
      vecs[14] = '{2'b01, 1'b1, 1'b0, 1'b0, {8'd0, 5'b10000}};
      vecs[15] = '{2'b00, 1'b0, 1'b0, 1'b0, {8'd0, 5'b00000}};

      bus.game_tick = 2'b00; bus.button_up = 1'b0; bus.button_down = 1'b0; bus.crash = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 32'(outs()), 32'd0);
      reset = 1'b0;

      // FSM transitions, one clock per vector.
      for (int i = 0; i < 16; i++) begin
         step(vecs[i].tick, vecs[i].up, vecs[i].dn, vecs[i].cr);
         $display("[TB] vec %0d: outs %h expected %h", i, outs(), vecs[i].exp);
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      end

      // Short tap: no hold extension.
      do_takeoff("tap");
      step(2'b00, 1'b0, 1'b0, 1'b0);
      check("tap_pulse_one_clk", 32'(bus.jump_pulse), 32'd0);
      foreach (h_plain[i]) exp_q.push_back(h_plain[i]);
      fly(1'b0, 999, 400);
      t1_ticks = phys_cnt;
      check("tap_land_ticks", 32'(t1_ticks), 32'd13);

      // Button held throughout: hold extension then normal arc.
      do_takeoff("hold");
      foreach (h_hold[i]) exp_q.push_back(h_hold[i]);
      fly(1'b1, 999, 400);
      check("hold_lands_later", 32'(phys_cnt > t1_ticks), 32'd1);
      step(2'b00, 1'b0, 1'b0, 1'b0);

      // Fast fall from the apex, then duck once on the ground.
      do_takeoff("fast");
      foreach (h_fast[i]) exp_q.push_back(h_fast[i]);
      fly(1'b0, 7, 400);
      step(2'b01, 1'b0, 1'b1, 1'b0);
      check("duck_after_land", 32'(bus.ducking), 32'd1);
      step(2'b01, 1'b0, 1'b0, 1'b0);
      check("unduck", 32'(bus.ducking), 32'd0);

      // Crash coinciding with a physics tick at height 15.
      do_takeoff("crash");
      for (int i = 0; i < 3; i++) exp_q.push_back(h_plain[i]);
      fly(1'b0, 999, 100);
      step(2'b11, 1'b0, 1'b0, 1'b1);
      $display("[TB] crash: outs %h", outs());
      check("crash_outs", 32'(outs()), 32'({8'd15, 5'b01000}));
      pulses = 0;
      for (int k = 0; k < 8; k++) step(phase_tick(k), 1'b0, 1'b0, 1'b1);
      check("game_over_frozen_pos", 32'(bus.player_position), 32'd15);
      check("game_over_no_pulses", 32'(pulses), 32'd0);
      step(2'b01, 1'b1, 1'b0, 1'b0);
      check("restart_outs", 32'(outs()), 32'({8'd0, 5'b10000}));
      step(2'b00, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of the ascent.
      do_takeoff("rst");
      for (int i = 0; i < 2; i++) exp_q.push_back(h_plain[i]);
      fly(1'b0, 999, 100);
      reset = 1'b1;
      step(2'b00, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      check("reset_mid_jump", 32'(outs()), 32'd0);
      step(2'b00, 1'b1, 1'b0, 1'b0);
      check("up_without_tick", 32'(outs()), 32'd0);
      step(2'b01, 1'b1, 1'b0, 1'b0);
      check("start_after_reset", 32'(outs()), 32'({8'd0, 5'b10000}));
      step(2'b00, 1'b0, 1'b0, 1'b0);

      // Press during descent at height 6, one tick[0] before landing.
      do_takeoff("buf");
      for (int i = 0; i < 12; i++) exp_q.push_back(h_plain[i]);
      fly(1'b0, 999, 400);
      step(2'b00, 1'b0, 1'b0, 1'b0);
      step(2'b01, 1'b1, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b0, 1'b0);
      step(2'b10, 1'b0, 1'b0, 1'b0);
      $display("[TB] buffered landing: outs %h", outs());
      check("land_pos", 32'(bus.player_position), 32'd0);
`ifdef JUMP_BUFFER_EN
      check("buf_jump_pulse", 32'(bus.jump_pulse), 32'd1);
      check("buf_jumping", 32'(bus.jumping), 32'd1);
`else
      check("buf_jump_pulse", 32'(bus.jump_pulse), 32'd0);
      check("buf_jumping", 32'(bus.jumping), 32'd0);
`endif
      for (int k = 0; k < 4; k++) step(phase_tick(k), 1'b0, 1'b0, 1'b0);
`ifdef JUMP_BUFFER_EN
      check("buf_next_height", 32'(bus.player_position), 32'd6);
      phys_cnt = 1;
      for (int i = 1; i < 13; i++) exp_q.push_back(h_plain[i]);
      fly(1'b0, 999, 400);
`else
      check("buf_next_height", 32'(bus.player_position), 32'd0);
      check("buf_wait_running", 32'(bus.jumping), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
